// File: rtl/ga_issue_queue.sv
// ga_issue_queue: request buffer and sequencer between the core's GA decode
// path and ga_coprocessor.
//   clk_i, rst_i                 clock, async active-high reset
//   core_req_valid_i/_ready_o    core request handshake, payload core_req_i
//   core_resp_*                  tagged response back to the core
//   flush_i                      drop all queued, not-yet-issued requests
//   copro_req_o / copro_resp_i   single-outstanding link to the coprocessor
//   occupancy_o, busy_o          FIFO fill level, activity flag
//   n_issued_o, n_errors_o       saturating status counters
package ga_pkg;
  typedef logic [3:0][15:0] ga_multivector_t;

  typedef struct packed {
    logic            valid;
    logic [3:0]      funct;
    ga_multivector_t a;
    ga_multivector_t b;
  } ga_req_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic            error;
    ga_multivector_t result;
  } ga_resp_t;
endpackage

module ga_issue_queue
  import ga_pkg::*;
#(
  parameter int Depth         = 4,
  parameter int TagWidth      = 3,
  parameter int TimeoutCycles = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          core_req_valid_i,
  output logic                          core_req_ready_o,
  input  logic [$bits(ga_req_t)-1:0]    core_req_i,
  output logic                          core_resp_valid_o,
  input  logic                          core_resp_ready_i,
  output logic [$bits(ga_multivector_t)-1:0] core_resp_result_o,
  output logic                          core_resp_error_o,
  output logic                          core_resp_timeout_o,
  output logic [TagWidth-1:0]           core_resp_tag_o,
  input  logic                          flush_i,
  output logic [$bits(ga_req_t)-1:0]    copro_req_o,
  input  logic [$bits(ga_resp_t)-1:0]   copro_resp_i,
  output logic [$clog2(Depth):0]        occupancy_o,
  output logic                          busy_o,
  output logic [15:0]                   n_issued_o,
  output logic [15:0]                   n_errors_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam int ToW  = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {IDLE, WAIT, SETTLE, RESP} state_t;

  ga_req_t  req_in;
  ga_resp_t resp_in;
  ga_req_t  req_out;
  assign req_in      = ga_req_t'(core_req_i);
  assign resp_in     = ga_resp_t'(copro_resp_i);
  assign copro_req_o = req_out;

  ga_req_t             fifo_req [Depth];
  logic [TagWidth-1:0] fifo_tag [Depth];
  logic [PtrW-1:0]     rd_ptr, wr_ptr;
  logic [CntW-1:0]     count;
  logic [TagWidth-1:0] tag_cnt;

  state_t              state;
  logic [ToW-1:0]      to_cnt;
  logic [TagWidth-1:0] inflight_tag;
  ga_multivector_t     resp_result;
  logic                resp_error, resp_timeout;
  logic [15:0]         n_issued, n_errors;

  logic empty, full, push, issue;

  assign empty = (count == '0);
  assign full  = (count == CntW'(Depth));
  // Gated with reset so every output reads 0 while reset is held.
  assign core_req_ready_o = !rst_i && !full;
  assign push  = core_req_valid_i && core_req_ready_o;
  // A still-high response valid (stale after a reset) blocks issue.
  assign issue = (state == IDLE) && !empty && resp_in.ready && !resp_in.valid && !flush_i;

  always_comb begin
    req_out = '0;
    if (!empty) begin
      req_out       = fifo_req[rd_ptr];
      req_out.valid = issue;
    end
  end

  // Payload storage needs no reset: it is only visible when the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      fifo_req[wr_ptr] <= req_in;
      fifo_tag[wr_ptr] <= tag_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      // The tag advances on every accept, including a push dropped by flush.
      if (push) tag_cnt <= tag_cnt + 1'b1;
      if (flush_i) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CntW'(push) - CntW'(issue);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      to_cnt       <= '0;
      inflight_tag <= '0;
      resp_result  <= '0;
      resp_error   <= 1'b0;
      resp_timeout <= 1'b0;
      n_issued     <= '0;
      n_errors     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            inflight_tag <= fifo_tag[rd_ptr];
            to_cnt       <= '0;
            if (n_issued != '1) n_issued <= n_issued + 16'd1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (resp_in.valid) begin
            resp_result  <= resp_in.result;
            resp_error   <= resp_in.error;
            resp_timeout <= 1'b0;
            state        <= SETTLE;
          end else if (to_cnt == ToW'(TimeoutCycles - 1)) begin
            resp_result  <= '0;
            resp_error   <= 1'b1;
            resp_timeout <= 1'b1;
            state        <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        // Absorbs the second valid cycle the coprocessor holds on success.
        SETTLE: begin
          if (!resp_in.valid) state <= RESP;
        end
        RESP: begin
          if (core_resp_ready_i) begin
            if (resp_error && (n_errors != '1)) n_errors <= n_errors + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_resp_valid_o   = (state == RESP);
  assign core_resp_result_o  = resp_result;
  assign core_resp_error_o   = resp_error;
  assign core_resp_timeout_o = resp_timeout;
  assign core_resp_tag_o     = inflight_tag;
  assign occupancy_o         = count;
  assign busy_o              = (state != IDLE) || !empty;
  assign n_issued_o          = n_issued;
  assign n_errors_o          = n_errors;

endmodule
